// File: rtl/keystream_gen.sv
// Key byte source for the XOR cipher: 16-bit Fibonacci LFSR, 8 steps per accepted byte, periodic re-key.
// Latency: start at edge N gives key_valid after edge N; one byte per cycle except a one-cycle REKEY bubble.
// Backpressure: with key_ready low, key_valid stays high and key/lfsr/byte_cnt hold.
module keystream_gen #(
  parameter int unsigned REKEY_LEN = 16,
  parameter logic [15:0] ALT_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        start,
  input  logic        stop,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [7:0]  key,
  output logic        busy,
  output logic [7:0]  byte_cnt,
  output logic [7:0]  epoch,
  output logic        rekey_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, REKEY} state_t;

  localparam logic [7:0] LAST_IDX = 8'(REKEY_LEN - 1);

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [7:0]  cnt_nxt, epoch_nxt;

  // Eight single-bit Fibonacci steps unrolled into one cycle.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < 8; i++) begin
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    end
    return v;
  endfunction

  // The all-zero state is a lock-up point for the LFSR, so it is never allowed in.
  function automatic logic [15:0] non_zero(input logic [15:0] s);
    return (s == 16'h0000) ? ALT_SEED : s;
  endfunction

  // Next-state decode; seed_load overrides every other control in the same cycle.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = byte_cnt;
    epoch_nxt = epoch;
    if (seed_load) begin
      lfsr_nxt  = non_zero(seed);
      cnt_nxt   = 8'd0;
      epoch_nxt = 8'd0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_nxt = RUN;
        end
        RUN: begin
          // key_valid is high throughout RUN, so ready alone marks a transfer.
          if (key_ready) begin
            lfsr_nxt = non_zero(lfsr_adv(lfsr));
            if (byte_cnt == LAST_IDX) begin
              cnt_nxt   = 8'd0;
              state_nxt = REKEY;
            end else begin
              cnt_nxt = byte_cnt + 8'd1;
            end
          end
          // A concurrent transfer still completes above; stop only redirects the state.
          if (stop) state_nxt = IDLE;
        end
        REKEY: begin
          lfsr_nxt  = non_zero({lfsr[7:0], lfsr[15:8]} ^ {8'h00, epoch});
          epoch_nxt = epoch + 8'd1;
          state_nxt = stop ? IDLE : RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, datapath and registered status flags all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= ALT_SEED;
      byte_cnt    <= 8'd0;
      epoch       <= 8'd0;
      key_valid   <= 1'b0;
      busy        <= 1'b0;
      rekey_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      lfsr        <= lfsr_nxt;
      byte_cnt    <= cnt_nxt;
      epoch       <= epoch_nxt;
      key_valid   <= (state_nxt == RUN);
      busy        <= (state_nxt == RUN) || (state_nxt == REKEY);
      rekey_pulse <= (state_nxt == REKEY);
    end
  end

  assign key = lfsr[7:0];

endmodule

// File: tb/tb_keystream_gen.sv
// Randomized and directed checks of keystream_gen against a behavioural model of the key stream.
// Model is updated at each posedge from the inputs driven on the preceding negedge.
// All DUT outputs are compared to the model at every negedge.
module tb_keystream_gen;

  localparam int unsigned RL  = 16;
  localparam logic [15:0] ALT = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load, start, stop, key_ready;
  logic [15:0] seed;
  logic        key_valid, busy, rekey_pulse;
  logic [7:0]  key, byte_cnt, epoch;

  int tests = 0;
  int fails = 0;

  keystream_gen #(.REKEY_LEN(RL), .ALT_SEED(ALT)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .start(start),
    .stop(stop), .key_ready(key_ready), .key_valid(key_valid), .key(key), .busy(busy),
    .byte_cnt(byte_cnt), .epoch(epoch), .rekey_pulse(rekey_pulse)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = stopped, 1 = streaming, 2 = re-keying
  int          m_mode;
  logic [15:0] m_lfsr;
  int          m_cnt;
  int          m_epoch;

  function automatic logic [15:0] next_key_state(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < 8; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return (v == 0) ? ALT : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lfsr = ALT; m_cnt = 0; m_epoch = 0;
  endtask

  task automatic model_step();
    logic [15:0] r;
    if (!rst_n) begin
      model_reset();
    end else if (seed_load) begin
      m_lfsr = (seed == 0) ? ALT : seed;
      m_cnt = 0; m_epoch = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (key_ready) begin
        m_lfsr = next_key_state(m_lfsr);
        m_cnt  = m_cnt + 1;
        if (m_cnt == RL) begin
          m_cnt = 0;
          m_mode = 2;
        end
      end
      if (stop) m_mode = 0;
    end else begin
      r = {m_lfsr[7:0], m_lfsr[15:8]} ^ 16'(m_epoch);
      m_lfsr  = (r == 0) ? ALT : r;
      m_epoch = (m_epoch + 1) % 256;
      m_mode  = stop ? 0 : 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("key_valid", 32'(key_valid), 32'(m_mode == 1));
    check("key", 32'(key), 32'(m_lfsr[7:0]));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("rekey_pulse", 32'(rekey_pulse), 32'(m_mode == 2));
    check("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    check("epoch", 32'(epoch), 32'(m_epoch));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    seed_load = 0; start = 0; stop = 0; key_ready = 0; seed = 16'h0;
  endtask

  logic [7:0] k_hold, c_hold;
  bit         seen;

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    compare();
    check("reset_key_lit", 32'(key), 32'h00E1);
    check("reset_valid_lit", 32'(key_valid), 32'h0);
    rst_n = 1;

    // Seed 0x0001 streams 01, 00, 2D.
    seed_load = 1; seed = 16'h0001; cyc();
    seed_load = 0; start = 1; key_ready = 1; cyc();
    start = 0;
    check("seed1_key0_lit", 32'(key), 32'h01);
    cyc(); check("seed1_key1_lit", 32'(key), 32'h00);
    cyc(); check("seed1_key2_lit", 32'(key), 32'h2D);

    // Backpressure: valid, key and count hold while ready is low.
    key_ready = 0;
    k_hold = key; c_hold = byte_cnt;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_valid", 32'(key_valid), 32'h1);
      check("hold_key", 32'(key), 32'(k_hold));
      check("hold_cnt", 32'(byte_cnt), 32'(c_hold));
    end

    // Run into the re-key bubble.
    key_ready = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (rekey_pulse) begin
        seen = 1;
        check("rekey_valid_lit", 32'(key_valid), 32'h0);
        check("rekey_cnt_lit", 32'(byte_cnt), 32'h0);
        check("rekey_epoch_before_lit", 32'(epoch), 32'h0);
      end
    end
    check("rekey_seen", 32'(seen), 32'h1);
    cyc();
    check("rekey_epoch_after_lit", 32'(epoch), 32'h1);
    check("rekey_resume_lit", 32'(key_valid), 32'h1);

    // Zero seed substitutes the alternate seed.
    key_ready = 0; seed_load = 1; seed = 16'h0000; cyc();
    seed_load = 0;
    check("zseed_key_lit", 32'(key), 32'hE1);
    check("zseed_idle_lit", 32'(key_valid), 32'h0);
    start = 1; cyc(); start = 0;
    check("zseed_run_key_lit", 32'(key), 32'hE1);

    // Stop with a concurrent transfer counts the byte; resume continues the stream.
    key_ready = 1; stop = 1; cyc();
    stop = 0; key_ready = 0;
    check("stop_idle_lit", 32'(key_valid), 32'h0);
    check("stop_cnt_lit", 32'(byte_cnt), 32'h1);
    start = 1; cyc(); start = 0;
    check("resume_key_lit", 32'(key), 32'hE4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      seed_load = ($urandom_range(0, 63) == 0);
      seed      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 31) == 0);
      key_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    // Asynchronous reset mid-run.
    idle_inputs();
    seed_load = 1; seed = 16'h5A5A; cyc();
    seed_load = 0; start = 1; key_ready = 1; cyc();
    start = 0;
    for (int i = 0; i < 20; i++) cyc();
    #2 rst_n = 0;
    #1;
    check("arst_valid_lit", 32'(key_valid), 32'h0);
    check("arst_cnt_lit", 32'(byte_cnt), 32'h0);
    check("arst_epoch_lit", 32'(epoch), 32'h0);
    check("arst_key_lit", 32'(key), 32'hE1);
    cyc();
    rst_n = 1;

    // seed_load beats start in the same cycle.
    key_ready = 0; seed_load = 1; start = 1; seed = 16'h1234; cyc();
    seed_load = 0; start = 0;
    check("prio_idle_lit", 32'(busy), 32'h0);
    check("prio_key_lit", 32'(key), 32'h34);
    start = 1; cyc(); start = 0;
    check("prio_run_lit", 32'(key_valid), 32'h1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
